scoreboard_tagged: RTL

//  Decode-stage issue scoreboard with tagged multi-port writeback and pipelined-unit occupancy tracking.

---
 rtl/scoreboard_tagged_if.sv | 60 ++++++
 rtl/scoreboard_tagged.sv | 139 +++++++++++++
 2 files changed

// File: rtl/scoreboard_tagged_if.sv
// Issue/writeback bundle between the decode stage (master) and the tagged scoreboard (slave).
// Parameters must match those of the scoreboard_tagged instance that the bundle is attached to.
interface scoreboard_tagged_if #(
    parameter int REG_ADDR_SIZE     = 4,
    parameter int PRED_ADDR_SIZE    = 2,
    parameter int FUNC_UNIT_OP_SIZE = 3,
    parameter int NUM_WB            = 2,
    parameter int TAG_SIZE          = 4
);
    logic                                  pred_ins;
    logic [PRED_ADDR_SIZE-1:0]             pred_addr;
    logic [REG_ADDR_SIZE-1:0]              reg_dest_addr;
    logic                                  reg_dest_valid;
    logic [REG_ADDR_SIZE-1:0]              reg_src1_addr;
    logic                                  reg_src1_valid;
    logic [REG_ADDR_SIZE-1:0]              reg_src2_addr;
    logic                                  reg_src2_valid;
    logic [PRED_ADDR_SIZE-1:0]             pred_dest_addr;
    logic                                  pred_dest_valid;
    logic [PRED_ADDR_SIZE-1:0]             pred_src1_addr;
    logic                                  pred_src1_valid;
    logic [PRED_ADDR_SIZE-1:0]             pred_src2_addr;
    logic                                  pred_src2_valid;
    logic [FUNC_UNIT_OP_SIZE-1:0]          func_unit;
    logic                                  issue;
    logic [NUM_WB-1:0]                     wr_reg;
    logic [NUM_WB*REG_ADDR_SIZE-1:0]       wr_reg_addr;
    logic [NUM_WB*TAG_SIZE-1:0]            wr_reg_tag;
    logic [NUM_WB-1:0]                     wr_pred;
    logic [NUM_WB*PRED_ADDR_SIZE-1:0]      wr_pred_addr;
    logic [NUM_WB*TAG_SIZE-1:0]            wr_pred_tag;
    logic [(1<<FUNC_UNIT_OP_SIZE)-1:0]     unit_done;
    logic [TAG_SIZE-1:0]                   issue_tag;
    logic                                  predicate_valid;
    logic                                  resource_stall;

    modport master (
        output pred_ins, pred_addr,
        output reg_dest_addr, reg_dest_valid, reg_src1_addr, reg_src1_valid,
        output reg_src2_addr, reg_src2_valid,
        output pred_dest_addr, pred_dest_valid, pred_src1_addr, pred_src1_valid,
        output pred_src2_addr, pred_src2_valid,
        output func_unit, issue,
        output wr_reg, wr_reg_addr, wr_reg_tag, wr_pred, wr_pred_addr, wr_pred_tag,
        output unit_done,
        input  issue_tag, predicate_valid, resource_stall
    );

    modport slave (
        input  pred_ins, pred_addr,
        input  reg_dest_addr, reg_dest_valid, reg_src1_addr, reg_src1_valid,
        input  reg_src2_addr, reg_src2_valid,
        input  pred_dest_addr, pred_dest_valid, pred_src1_addr, pred_src1_valid,
        input  pred_src2_addr, pred_src2_valid,
        input  func_unit, issue,
        input  wr_reg, wr_reg_addr, wr_reg_tag, wr_pred, wr_pred_addr, wr_pred_tag,
        input  unit_done,
        output issue_tag, predicate_valid, resource_stall
    );
endinterface

// File: rtl/scoreboard_tagged.sv
// Decode-stage issue scoreboard: per-register busy/tag tracking with tagged writeback,
// per-unit occupancy counters and an outstanding-tag window.
module scoreboard_tagged #(
    parameter int REG_ADDR_SIZE     = 4,
    parameter int PRED_ADDR_SIZE    = 2,
    parameter int FUNC_UNIT_OP_SIZE = 3,
    parameter int NUM_WB            = 2,
    parameter int TAG_SIZE          = 4,
    parameter int UNIT_DEPTH        = 2,
    parameter int WAW_STALL         = 1,
    parameter int WB_BYPASS         = 1
) (
    input logic                 clk,
    input logic                 reset,
    scoreboard_tagged_if.slave  bus
);
    localparam int REG_FILE_SIZE  = 1 << REG_ADDR_SIZE;
    localparam int PRED_FILE_SIZE = 1 << PRED_ADDR_SIZE;
    localparam int NUM_FUNC_UNITS = 1 << FUNC_UNIT_OP_SIZE;
    localparam int PW             = $clog2(2*NUM_WB+1);
    localparam int CW             = TAG_SIZE + PW + 1;

    logic [REG_FILE_SIZE-1:0]  r_reg_busy;
    logic [TAG_SIZE-1:0]       r_reg_tag [REG_FILE_SIZE];
    logic [PRED_FILE_SIZE-1:0] r_pred_busy;
    logic [TAG_SIZE-1:0]       r_pred_tag [PRED_FILE_SIZE];
    logic [TAG_SIZE-1:0]       r_next_tag;
    logic [TAG_SIZE-1:0]       r_outstanding;
    logic [2:0]                r_unit_cnt [NUM_FUNC_UNITS];

    logic [REG_FILE_SIZE-1:0]  w_reg_wb_hit;
    logic [PRED_FILE_SIZE-1:0] w_pred_wb_hit;
    logic [REG_FILE_SIZE-1:0]  w_reg_busy_eff;
    logic [PRED_FILE_SIZE-1:0] w_pred_busy_eff;
    logic                      w_guard_busy;
    logic                      w_raw;
    logic                      w_waw;
    logic                      w_unit_full;
    logic                      w_tag_full;
    logic                      w_stall;
    logic                      w_accept;
    logic [PW-1:0]             w_wb_count;
    logic [CW-1:0]             w_out_sum;
    logic [TAG_SIZE-1:0]       w_out_next;

    // A writeback only counts for a register when its tag equals the stored (latest) tag.
    always_comb begin
        w_reg_wb_hit  = '0;
        w_pred_wb_hit = '0;
        for (int i = 0; i < REG_FILE_SIZE; i++) begin
            for (int k = 0; k < NUM_WB; k++) begin
                if (bus.wr_reg[k] &&
                    bus.wr_reg_addr[k*REG_ADDR_SIZE +: REG_ADDR_SIZE] == REG_ADDR_SIZE'(i) &&
                    bus.wr_reg_tag[k*TAG_SIZE +: TAG_SIZE] == r_reg_tag[i])
                    w_reg_wb_hit[i] = 1'b1;
            end
        end
        for (int i = 0; i < PRED_FILE_SIZE; i++) begin
            for (int k = 0; k < NUM_WB; k++) begin
                if (bus.wr_pred[k] &&
                    bus.wr_pred_addr[k*PRED_ADDR_SIZE +: PRED_ADDR_SIZE] == PRED_ADDR_SIZE'(i) &&
                    bus.wr_pred_tag[k*TAG_SIZE +: TAG_SIZE] == r_pred_tag[i])
                    w_pred_wb_hit[i] = 1'b1;
            end
        end
    end

    assign w_reg_busy_eff  = (WB_BYPASS != 0) ? (r_reg_busy & ~w_reg_wb_hit) : r_reg_busy;
    assign w_pred_busy_eff = (WB_BYPASS != 0) ? (r_pred_busy & ~w_pred_wb_hit) : r_pred_busy;

    assign w_guard_busy = bus.pred_ins & w_pred_busy_eff[bus.pred_addr];
    assign w_raw = (bus.reg_src1_valid  & w_reg_busy_eff[bus.reg_src1_addr])
                 | (bus.reg_src2_valid  & w_reg_busy_eff[bus.reg_src2_addr])
                 | (bus.pred_src1_valid & w_pred_busy_eff[bus.pred_src1_addr])
                 | (bus.pred_src2_valid & w_pred_busy_eff[bus.pred_src2_addr])
                 | w_guard_busy;
    assign w_waw = (WAW_STALL != 0) &
                   ((bus.reg_dest_valid  & r_reg_busy[bus.reg_dest_addr]) |
                    (bus.pred_dest_valid & r_pred_busy[bus.pred_dest_addr]));
    assign w_unit_full = (r_unit_cnt[bus.func_unit] == 3'(UNIT_DEPTH));
    assign w_tag_full  = &r_outstanding;

    // Handshake: issue is a request, resource_stall the inverted grant; an instruction is
    // accepted in exactly the cycle issue=1 and resource_stall=0, otherwise nothing changes.
    assign w_stall  = w_raw | w_waw | w_unit_full | w_tag_full;
    assign w_accept = bus.issue & ~w_stall;

    assign bus.resource_stall  = w_stall;
    assign bus.predicate_valid = ~w_guard_busy;
    assign bus.issue_tag       = r_next_tag;

    always_comb begin
        w_wb_count = '0;
        for (int k = 0; k < NUM_WB; k++)
            w_wb_count = w_wb_count + PW'(bus.wr_reg[k]) + PW'(bus.wr_pred[k]);
    end

    // Every valid writeback retires one outstanding slot; the count floors at zero.
    assign w_out_sum  = CW'(r_outstanding) + CW'(w_accept);
    assign w_out_next = (w_out_sum > CW'(w_wb_count)) ?
                        TAG_SIZE'(w_out_sum - CW'(w_wb_count)) : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_reg_busy    <= '0;
            r_pred_busy   <= '0;
            r_next_tag    <= '0;
            r_outstanding <= '0;
            for (int i = 0; i < REG_FILE_SIZE; i++)  r_reg_tag[i]  <= '0;
            for (int i = 0; i < PRED_FILE_SIZE; i++) r_pred_tag[i] <= '0;
            for (int u = 0; u < NUM_FUNC_UNITS; u++) r_unit_cnt[u] <= '0;
        end else begin
            for (int i = 0; i < REG_FILE_SIZE; i++) begin
                if (w_accept && bus.reg_dest_valid && bus.reg_dest_addr == REG_ADDR_SIZE'(i)) begin
                    r_reg_busy[i] <= 1'b1;
                    r_reg_tag[i]  <= r_next_tag;
                end else if (w_reg_wb_hit[i]) begin
                    r_reg_busy[i] <= 1'b0;
                end
            end
            for (int i = 0; i < PRED_FILE_SIZE; i++) begin
                if (w_accept && bus.pred_dest_valid && bus.pred_dest_addr == PRED_ADDR_SIZE'(i)) begin
                    r_pred_busy[i] <= 1'b1;
                    r_pred_tag[i]  <= r_next_tag;
                end else if (w_pred_wb_hit[i]) begin
                    r_pred_busy[i] <= 1'b0;
                end
            end
            if (w_accept)
                r_next_tag <= r_next_tag + 1'b1;
            r_outstanding <= w_out_next;
            // A completion on an idle unit is dropped rather than wrapping the counter.
            for (int u = 0; u < NUM_FUNC_UNITS; u++)
                r_unit_cnt[u] <= r_unit_cnt[u]
                               + 3'(w_accept && bus.func_unit == FUNC_UNIT_OP_SIZE'(u))
                               - 3'(bus.unit_done[u] && r_unit_cnt[u] != 3'd0);
        end
    end
endmodule
